// File: rtl/sevenseg_scan_n.sv
// sevenseg_scan_n: N-digit multiplexed seven-segment scanner with
// anti-ghost dead-time, PWM dimming and frame-synchronous shadow loads.
module sevenseg_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_CYC  = 64,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cathod,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0] SLOT_LAST = SW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLOT_ACT  = SW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic                pend_q;

  logic [NUM_DIGITS-1:0][6:0] seg_sh_q;
  logic [NUM_DIGITS-1:0]      dp_sh_q;
  logic [NUM_DIGITS-1:0]      den_sh_q;

  logic [NUM_DIGITS-1:0] an_hot_q, an_hot_d;
  logic [6:0]            seg_hot_q, seg_hot_d;
  logic                  dp_hot_q, dp_hot_d;
  logic                  fd_q;
  logic                  cath_q;

  logic slot_last;
  logic frame_end;
  logic in_blank;
  logic bright_ok;
  logic lit;
  logic pol;

  if (BLANK_CYC == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = slot_q < SLOT_ACT;
  end

  always_comb begin
    slot_last = slot_q == SLOT_LAST;
    frame_end = slot_last && (dig_q == DIG_LAST);

    slot_d = slot_last ? '0 : slot_q + 1'b1;
    dig_d  = dig_q;
    if (slot_last)
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;

    pwm_d = (slot_d == SLOT_ACT) ? '0 : pwm_q + 1'b1;

    bright_ok = (&brightness) || (pwm_q < brightness);
    lit = !in_blank && den_sh_q[dig_q] && bright_ok;

    // Internal drive is active-high; polarity is applied at the pins.
    an_hot_d = '0;
    if (lit)
      an_hot_d[dig_q] = 1'b1;
    seg_hot_d = lit ? ~seg_sh_q[dig_q] : 7'b0;
    dp_hot_d  = lit && dp_sh_q[dig_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q    <= '0;
      dig_q     <= '0;
      pwm_q     <= '0;
      pend_q    <= 1'b0;
      seg_sh_q  <= '1;
      dp_sh_q   <= '0;
      den_sh_q  <= '0;
      an_hot_q  <= '0;
      seg_hot_q <= '0;
      dp_hot_q  <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      fd_q <= en && frame_end;
      if (en) begin
        slot_q    <= slot_d;
        dig_q     <= dig_d;
        pwm_q     <= pwm_d;
        an_hot_q  <= an_hot_d;
        seg_hot_q <= seg_hot_d;
        dp_hot_q  <= dp_hot_d;
      end
      if (en && frame_end && (pend_q || load)) begin
        seg_sh_q <= seg_in;
        dp_sh_q  <= dp_in;
        den_sh_q <= digit_en;
        pend_q   <= 1'b0;
      end else if (load) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cath_q <= cathod;
  end

  // In reset the pins follow the live board type so they go dark at once.
  assign pol = rst ? cath_q : cathod;

  assign an         = pol ? ~an_hot_q  : an_hot_q;
  assign seg_out    = pol ? ~seg_hot_q : seg_hot_q;
  assign dp_out     = pol ? ~dp_hot_q  : dp_hot_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// tb_sevenseg_scan_n: randomized scoreboard bench; expected pins come
// from a time-position model of the scan, checked by a negedge monitor.
module tb_sevenseg_scan_n;

  localparam int ND    = 4;
  localparam int PS    = 20;
  localparam int BL    = 4;
  localparam int BW    = 2;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cathod;
  logic [7*ND-1:0] seg_in;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] digit_en;
  logic [BW-1:0] brightness;
  logic          load;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [ND-1:0] an;
  logic          frame_done;

  sevenseg_scan_n #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS),
    .BLANK_CYC (BL),
    .BRIGHT_W  (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cathod    (cathod),
    .seg_in    (seg_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .brightness(brightness),
    .load      (load),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          fd;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Model state: enabled cycles since reset plus shadow contents.
  int            t;
  logic [6:0]    sh_seg[ND];
  logic [ND-1:0] sh_dp;
  logic [ND-1:0] sh_den;
  bit            pend;
  logic [ND-1:0] m_an;
  logic [6:0]    m_seg;
  logic          m_dp;

  task automatic tick();
    exp_t e;
    bit   fd;
    int   pos, d, s, pwm;
    bit   lit;
    fd = 1'b0;
    if (!rst) begin
      t = 0;
      for (int i = 0; i < ND; i++) sh_seg[i] = 7'h7F;
      sh_dp  = '0;
      sh_den = '0;
      pend   = 1'b0;
      m_an   = '0;
      m_seg  = '0;
      m_dp   = 1'b0;
    end else if (en) begin
      pos = t % FRAME;
      d   = pos / PS;
      s   = pos % PS;
      pwm = (s - BL) % (1 << BW);
      lit = (s >= BL) && sh_den[d] &&
            (brightness == 2'b11 || pwm < int'(brightness));
      m_an  = lit ? ND'(1 << d) : '0;
      m_seg = lit ? ~sh_seg[d] : 7'b0;
      m_dp  = lit && sh_dp[d];
      fd    = (pos == FRAME - 1);
      if (fd && (pend || load)) begin
        for (int i = 0; i < ND; i++) sh_seg[i] = seg_in[7*i +: 7];
        sh_dp  = dp_in;
        sh_den = digit_en;
        pend   = 1'b0;
      end else if (load) begin
        pend = 1'b1;
      end
      t++;
    end else if (load) begin
      pend = 1'b1;
    end
    e.an  = cathod ? ~m_an  : m_an;
    e.seg = cathod ? ~m_seg : m_seg;
    e.dp  = cathod ? ~m_dp  : m_dp;
    e.fd  = fd;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until(input int m);
    while ((t % FRAME) != m) tick();
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg_out !== 7'h7F ||
        dp_out !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b fd=%b required 1111 1111111 1 0",
               an, seg_out, dp_out, frame_done);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({an, seg_out, dp_out, frame_done} !== e) begin
          errors++;
          $display("FAIL pins @%0t: an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                   $time, an, seg_out, dp_out, frame_done, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    en         = 1'b1;
    cathod     = 1'b1;
    load       = 1'b0;
    brightness = 2'b11;
    digit_en   = 4'hF;
    dp_in      = 4'h0;
    seg_in     = {7'h30, 7'h24, 7'h79, 7'h40};
    run(3);
    rst = 1'b1;

    load = 1'b1; tick(); load = 1'b0;
    run(3 * FRAME);

    cathod = 1'b0;
    seg_in[6:0] = 7'b1000000;
    load = 1'b1; tick(); load = 1'b0;
    run(2 * FRAME);

    cathod = 1'b1;
    brightness = 2'd2; run(FRAME);
    brightness = 2'd1; run(FRAME);
    brightness = 2'd0; run(FRAME);
    brightness = 2'd3;

    run_until(2 * PS + 5);
    seg_in = 28'($urandom);
    load = 1'b1; tick(); load = 1'b0;
    run(FRAME);
    run_until(FRAME - 1);
    seg_in = 28'($urandom);
    load = 1'b1; tick(); load = 1'b0;
    run(FRAME);

    digit_en = 4'b0011;
    dp_in    = 4'b0001;
    load = 1'b1; tick(); load = 1'b0;
    run(2 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 19) == 0);
      brightness = BW'($urandom);
      if ($urandom_range(0, 49) == 0) cathod = ~cathod;
      seg_in   = 28'($urandom);
      dp_in    = ND'($urandom);
      digit_en = ND'($urandom);
      tick();
    end

    en = 1'b1; cathod = 1'b1; brightness = 2'd3;
    digit_en = 4'hF;
    load = 1'b1; tick(); load = 1'b0;
    run(FRAME);
    run_until(PS + 7);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(5);
    async_reset_check();
    run(3);
    rst = 1'b1;
    run(FRAME + 10);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
